// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the multi-cycle ALU:
// operation codes carried on sel and the execution state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_NOT = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider datapath. Loaded once by the parent, then
// stepped one quotient bit per cycle; quo_next_o is the quotient register
// value after the current step, so the parent can latch the final quotient
// on the last step edge.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_next_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  // The shifted partial remainder needs WIDTH+1 bits; when its top bit is
  // set it always exceeds the divisor and the true difference fits in WIDTH.
  always_comb begin
    shifted    = {rem_q, quo_q[WIDTH-1]};
    ge         = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_q);
    diff       = shifted[WIDTH-1:0] - dvs_q;
    rem_d      = ge ? diff : shifted[WIDTH-1:0];
    quo_next_o = {quo_q[WIDTH-2:0], ge};
  end

  // Partial remainder, quotient shift register and captured divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_next_o;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execution ALU. Logic/add/compare ops finish in one cycle;
// multiply (shift-add) and divide (restoring) iterate WIDTH cycles behind
// a start/busy/done handshake. Divider present only when ALU_DIV_EN is
// defined; otherwise sel=DIV behaves as an unused single-cycle code.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | mul/div iterating, one step per cycle, start ignored
// DONE  | result valid (done pulse); accepts start like IDLE
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] mul_add;

`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic             div_load, div_step;
  logic [WIDTH-1:0] div_quo_next;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a),
    .divisor_i  (b),
    .quo_next_o (div_quo_next)
  );
`endif

  // Single-cycle operation results straight from the live operands.
  always_comb begin
    sc_result = '0;
    case (sel)
      ALU_ADD: sc_result = a + b;
      ALU_SUB: sc_result = a - b;
      ALU_AND: sc_result = a & b;
      ALU_OR:  sc_result = a | b;
      ALU_XOR: sc_result = a ^ b;
      ALU_NOT: sc_result = ~a;
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: sc_result = '0;
    endcase
  end

  // Partial product after adding the current multiplicand (if bit set).
  assign mul_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state logic: accept, iterate, and write result on completion.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_DIV_EN
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    div_load = 1'b0;
    div_step = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (sel == ALU_MUL) begin
            state_d  = RUN;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
`ifdef ALU_DIV_EN
            is_div_d = 1'b0;
          end else if (sel == ALU_DIV && b != '0) begin
            state_d  = RUN;
            cnt_d    = '0;
            is_div_d = 1'b1;
            div_load = 1'b1;
          end else if (sel == ALU_DIV) begin
            state_d  = DONE;
            result_d = '1;
            zero_d   = 1'b0;
            dbz_d    = 1'b1;
`endif
          end else begin
            state_d  = DONE;
            result_d = sc_result;
            zero_d   = (sc_result == '0);
`ifdef ALU_DIV_EN
            dbz_d    = 1'b0;
`endif
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
`ifdef ALU_DIV_EN
        if (is_div_q) begin
          div_step = 1'b1;
        end else
`endif
        begin
          acc_d    = mul_add;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        if (cnt_q == LAST) begin
          state_d  = DONE;
          result_d = mul_add;
`ifdef ALU_DIV_EN
          if (is_div_q) result_d = div_quo_next;
          dbz_d    = 1'b0;
`endif
          zero_d   = (result_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, iteration and result registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_DIV_EN
      is_div_q <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_DIV_EN
      is_div_q <= is_div_d;
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
`ifdef ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle execution ALU, directly downstream of the ALU control decoder: consumes the 4-bit `sel` operation code plus register operands and produces a registered result with zero flag. Logic/add/compare ops complete in one cycle. Multiply and divide run iteratively behind a start/busy/done handshake, so the control unit stalls the pipeline only for those ops.

## Interface
- `WIDTH`, default 32, operand/result width (≥4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `sel`  in  4  operation code from ALU control (encoding below).
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `result`  out  WIDTH  registered result; holds until next `done`.
- `zero`  out  1  registered, `result == 0`.
- `busy`  out  1  iterative op in progress.
- `done`  out  1  one-cycle pulse; `result`/`zero`/`div_by_zero` valid and updated.
- `div_by_zero`  out  1  set with `done` for divide with `b == 0`, else cleared on `done`.

## Operation
- Encoding: 0000 add, 0001 sub (a−b), 0010 mul, 0011 div, 0100 and, 0101 or, 0110 xor, 0111 not (~a, b ignored), 1000 slt (signed a<b → 1 else 0). Codes 1001–1111: result 0, single-cycle.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Mul: unsigned shift-add, low WIDTH bits of product kept (identical for signed operands).
- Div: unsigned restoring division, quotient returned; remainder discarded.
- Div with `b == 0`: no iteration; result all ones, `div_by_zero = 1`, single-cycle latency.
- Operands and `sel` captured at accept edge; later input changes have no effect on an op in flight.
- States: IDLE, RUN, DONE.
  - IDLE + start + single-cycle op → DONE (result written at same edge).
  - IDLE + start + mul/div (b≠0 for div) → RUN, iteration counter = 0.
  - RUN: one iteration per cycle; after iteration WIDTH−1 → DONE, result written.
  - DONE: `done = 1`; behaves as IDLE for accepting `start` (back-to-back ops allowed); no start → IDLE.
- `start` while RUN ignored (not queued).
- `rst` at any time (incl. mid-RUN): state IDLE, op aborted, no `done` emitted.

## Timing
- Reset values: `result` 0, `zero` 1, `busy` 0, `done` 0, `div_by_zero` 0.
- Single-cycle op: start high in cycle N → `done` high in cycle N+1.
- Mul/div: start in cycle N → `busy` high cycles N+1..N+WIDTH → `done` in cycle N+WIDTH+1, `busy` low then.
- `done` never high two cycles for one op; consecutive `done` only for back-to-back accepted ops.
- `busy` and `done` never both high.

## Configuration
- `ALU_DIV_EN` defined: iterative divider present as above.
- Undefined: no divider logic; sel 0011 is single-cycle, result 0; `div_by_zero` tied 0.

## Structure
- Package `alu_pkg`: `sel` code constants (ALU_ADD … ALU_SLT), state enum (IDLE/RUN/DONE), shared by ALU control decoder and this block.
- Sub-module `alu_divider`: restoring divider datapath (partial remainder, quotient shift register), stepped by parent; instantiated only under `ALU_DIV_EN`. Multiplier and single-cycle ops stay in top level.

## Test plan
- Reset, then add a=5,b=7 → `done` in cycle after start, result 12, zero 0; sub 7−7 → result 0, zero 1.
- slt a=−3 (0xFFFFFFFD), b=2 → 1; slt a=2,b=−3 → 0; not a=0 → 0xFFFFFFFF.
- mul 0x0001_0000 × 0x0001_0000 (WIDTH=32) → result 0, `busy` 32 cycles, `done` exactly 33 cycles after start; mul 123×456 → 56088.
- div 100/7 → 14, latency 33; div 5/0 → 0xFFFFFFFF, `div_by_zero` 1, latency 1; next add clears `div_by_zero`.
- start with different sel/operands pulsed during RUN → ignored, original mul result returned; start held in DONE cycle → second op accepted back-to-back.
- rst asserted mid-divide (cycle 10 of RUN) → outputs return to reset values next cycle, no `done` ever emitted for that op; build without `ALU_DIV_EN`: div 100/7 → 0 in 1 cycle.
